div32: RTL and testbench
========================

# div32

Sequential 32-bit unsigned integer divider and the inverse datapath of the array multiplier `mul32`. It accepts one dividend/divisor pair per `start` pulse and runs a radix-2 restoring algorithm that resolves one quotient bit per clock. It returns quotient and remainder with a single-cycle `done` pulse. It sits beside `mul32` in the arithmetic unit and shares that block's 64-bit-product / 32-bit-operand conventions.

## Interface
- `DW`, 32, operand width; even, ≥ 2; iteration counter is `$clog2(DW)+1` bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  DW  numerator; sampled on the accepted `start` edge.
- `divisor`  in  DW  denominator; sampled on the accepted `start` edge.
- `signed_op`  in  1  only present with `DIV32_SIGNED_EN`; sampled with operands.
- `busy`  out  1  high from the accepted start until the cycle `done` rises (inclusive of RUN).
- `done`  out  1  one-cycle pulse marking valid results.
- `quotient`  out  DW  result; held until the next accepted start.
- `remainder`  out  DW  result; held until the next accepted start.
- `dbz`  out  1  divide-by-zero flag for the last operation; held with results.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: `start`=1 and `divisor`≠0.
  - Load the partial remainder R=0 and the shift register Q=dividend.
  - Latch the divisor.
  - Clear `dbz`.
  - Set count=DW.
- IDLE → DONE: `start`=1 and `divisor`=0.
  - `quotient`=all ones, `remainder`=dividend, `dbz`=1.
- RUN, each cycle:
  - T = {R[DW-1:0], Q[DW-1]} − {1'b0, divisor}, computed as a (DW+1)-bit subtraction.
  - If T is non-negative: R=T, shift 1 into Q. Otherwise R={R,Q[DW-1]}, shift 0 into Q.
  - count decrements by 1.
  - When count reaches 1, the current cycle is the final iteration: move to DONE and register Q/R into `quotient`/`remainder`.
- DONE: assert `done` for exactly one cycle, then go to IDLE unconditionally.
- `start` in RUN or DONE is ignored; it is not queued.
- Invariant on completion with `dbz`=0: dividend = quotient·divisor + remainder, and remainder < divisor.

## Timing
- Reset values (async assert, sync-safe release):
  - state=IDLE, `busy`=0, `done`=0, `dbz`=0.
  - `quotient`=0, `remainder`=0, internal count/R/Q=0.
- Latency counts from the clock edge that samples `start` (edge 0):
  - Normal divide: `done` is high in the cycle after edge DW+1 (33 for DW=32). `busy` is high from edge 0 through edge DW+1.
  - Divide-by-zero: `done` is high in the cycle after edge 1. `busy` is high for one cycle.
- Results change only on the edge entering DONE. They are stable while `done`=1 and afterwards.
- `start` may be asserted in the same cycle `done` is high. It is not accepted until the following IDLE cycle, so the back-to-back throughput is one operation per DW+2 cycles.
- Reset asserted mid-RUN:
  - The operation aborts immediately and all outputs return to their reset values.
  - `done` never pulses for the aborted operation.

## Configuration
- `DIV32_SIGNED_EN` defined:
  - The `signed_op` port exists.
  - When `signed_op`=1, operands are treated as two's complement. Their magnitudes are loaded at IDLE→RUN and the sign of each result is corrected in the registering step, so latency is unchanged.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - The overflow case −2^(DW−1) / −1 gives `quotient`=0x80000000, `remainder`=0, `dbz`=0.
  - Divide-by-zero returns `quotient`=all ones and `remainder`=dividend (raw bits).
- `DIV32_SIGNED_EN` not defined: the `signed_op` port and all sign logic are absent, and the block is unsigned only.

## Structure
- Package `div32_pkg` holds:
  - the `div_state_e` enum (IDLE/RUN/DONE);
  - the `DIV_DW` default constant;
  - the `DBZ_QUOTIENT` constant (all ones).
- One sub-module, `div_step`: combinational (DW+1)-bit trial subtract and restore for a single iteration. Inputs are R, the incoming Q bit and the divisor; outputs are the next R and the quotient bit.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- 100 / 7 → `quotient`=14, `remainder`=2, `dbz`=0; `done` pulse exactly 33 cycles after the start edge; `busy` low afterwards.
- 0xFFFFFFFF / 1 → `quotient`=0xFFFFFFFF, `remainder`=0. Also 3 / 10 → `quotient`=0, `remainder`=3.
- 5 / 0 → `quotient`=0xFFFFFFFF, `remainder`=5, `dbz`=1; `done` one cycle after the start edge.
- Second `start` with different operands pulsed at cycle 10 of a 100/7 run → ignored; results are still 14/2. Then `rst_n` low at cycle 10 of a new run → all outputs 0 and no `done` pulse.
- Back-to-back: `start` held high continuously, operand pairs 1000/10 then 9/4 → results 100/0 and then 2/1; `done` pulses 34 cycles apart.
- With `DIV32_SIGNED_EN` and `signed_op`=1: −7 / 2 → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0.

Source files
------------

// File: rtl/div32_pkg.sv
// div32_pkg: shared FSM state type and constants for the div32 divider.
package div32_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
  localparam int DIV_DW = 32;
  localparam logic [63:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/div32_step.sv
// div_step: one restoring-division iteration (trial subtract, keep or restore).
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] r,
  input  logic          q_in,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);
  logic [DW:0] t;
  always_comb begin
    t      = {r, q_in} - {1'b0, d};
    q_bit  = ~t[DW];
    r_next = q_bit ? t[DW-1:0] : {r[DW-2:0], q_in};
  end
endmodule

// File: rtl/div32.sv
// div32: sequential radix-2 restoring divider, one quotient bit per clock.
// Optional two's-complement mode when DIV32_SIGNED_EN is defined.
module div32
  import div32_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic          signed_op,
`endif
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          dbz
);
  localparam int CW = $clog2(DW) + 1;
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] r_q, r_d, q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [DW-1:0] r_nx, a_mag, b_mag, q_fin;
  logic          dbz_q, dbz_d, done_q, done_d, q_bit, accept;
`ifdef DIV32_SIGNED_EN
  logic          qneg_q, qneg_d, rneg_q, rneg_d, a_neg, b_neg;
`endif

  div_step #(.DW(DW)) u_step (
    .r(r_q), .q_in(q_q[DW-1]), .d(d_q), .r_next(r_nx), .q_bit(q_bit)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start)             state_d = (divisor == '0) ? DONE : RUN;
    else if (state_q == RUN && cnt_q == CW'(1)) state_d = DONE;
    else if (state_q == DONE)                 state_d = IDLE;
  end

  always_comb begin
    busy   = state_q != IDLE;
    done_d = state_q == DONE;
  end

  always_comb begin
    accept = state_q == IDLE && start;
    q_fin  = {q_q[DW-2:0], q_bit};
`ifdef DIV32_SIGNED_EN
    a_neg  = signed_op & dividend[DW-1];
    b_neg  = signed_op & divisor[DW-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`else
    a_mag  = dividend;
    b_mag  = divisor;
`endif
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept && divisor == '0) begin
      quo_d = DW'(DBZ_QUOTIENT);
      rem_d = dividend;
      dbz_d = 1'b1;
    end else if (accept) begin
      r_d   = '0;
      q_d   = a_mag;
      d_d   = b_mag;
      dbz_d = 1'b0;
      cnt_d = CW'(DW);
`ifdef DIV32_SIGNED_EN
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
`endif
    end else if (state_q == RUN) begin
      r_d   = r_nx;
      q_d   = q_fin;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
`ifdef DIV32_SIGNED_EN
        quo_d = qneg_q ? -q_fin : q_fin;
        rem_d = rneg_q ? -r_nx : r_nx;
`else
        quo_d = q_fin;
        rem_d = r_nx;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef DIV32_SIGNED_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
`ifdef DIV32_SIGNED_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end

  always_comb begin
    done      = done_q;
    quotient  = quo_q;
    remainder = rem_q;
    dbz       = dbz_q;
  end
endmodule

// File: tb/tb_div32.sv
// tb_div32: randomized self-checking bench for div32 against an arithmetic model.
module tb_div32;
  logic        clk = 0, rst_n = 0, start = 0, signed_op = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic        busy, done, dbz;
  logic [31:0] quotient, remainder;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  div32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef DIV32_SIGNED_EN
    .signed_op(signed_op),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = (b == 0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic z, output int lat);
    @(negedge clk);
    dividend = a; divisor = b; signed_op = s; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = quotient; r = remainder; z = dbz;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r, eq, er;
    logic z, ez;
    int lat;
    model(a, b, s, eq, er, ez);
    run_op(a, b, s, q, r, z, lat);
    total += 4;
    if (q !== eq) begin bad++; $display("FAIL %s quotient got %h exp %h", name, q, eq); end
    if (r !== er) begin bad++; $display("FAIL %s remainder got %h exp %h", name, r, er); end
    if (z !== ez) begin bad++; $display("FAIL %s dbz got %b exp %b", name, z, ez); end
    if (lat !== (ez ? 1 : 33)) begin bad++; $display("FAIL %s latency got %0d exp %0d", name, lat, ez ? 1 : 33); end
    @(negedge clk);
    total++;
    if (done !== 0 || busy !== 0 || quotient !== eq || remainder !== er) begin
      bad++; $display("FAIL %s after done busy=%b done=%b q=%h r=%h", name, busy, done, quotient, remainder);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, dbz, quotient, remainder} !== 67'd0) begin
      bad++; $display("FAIL reset busy=%b done=%b dbz=%b q=%h r=%h exp all 0", busy, done, dbz, quotient, remainder);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_op("100/7", 100, 7, 0);
    check_op("max/1", 32'hFFFF_FFFF, 1, 0);
    check_op("3/10", 3, 10, 0);
    check_op("5/0", 5, 0, 0);
    check_op("0/9", 0, 9, 0);
    check_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      check_op("rand", a, b, 0);
    end
  endtask

  task automatic test_ignore();
    int lat = 0;
    @(negedge clk);
    dividend = 100; divisor = 7; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      if (lat == 10) begin
        @(negedge clk);
        dividend = 55; divisor = 3; start = 1;
        @(posedge clk);
        lat++;
        start = #1 0;
      end
      @(negedge clk);
    end
    total += 3;
    if (lat !== 33) begin bad++; $display("FAIL ignore latency got %0d exp 33", lat); end
    if (quotient !== 14) begin bad++; $display("FAIL ignore quotient got %0d exp 14", quotient); end
    if (remainder !== 2) begin bad++; $display("FAIL ignore remainder got %0d exp 2", remainder); end
  endtask

  task automatic test_abort();
    int seen = 0;
    @(negedge clk);
    dividend = 1234; divisor = 5; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if ({busy, done, dbz, quotient, remainder} !== 67'd0) begin
      bad++; $display("FAIL abort outputs busy=%b done=%b dbz=%b q=%h r=%h exp all 0", busy, done, dbz, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort done pulses got %0d exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    int t = 0, n = 0;
    int tdone[2];
    logic [31:0] qv[2], rv[2];
    @(negedge clk);
    dividend = 1000; divisor = 10; start = 1;
    @(posedge clk);
    @(negedge clk);
    dividend = 9; divisor = 4;
    while (n < 2 && t < 200) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (done) begin
        tdone[n] = t; qv[n] = quotient; rv[n] = remainder; n++;
        if (n == 2) start = 0;
      end
    end
    start = 0;
    total += 6;
    if (n !== 2) begin bad++; $display("FAIL b2b pulses got %0d exp 2", n); end
    if (n == 2 && tdone[1] - tdone[0] !== 34) begin bad++; $display("FAIL b2b spacing got %0d exp 34", tdone[1] - tdone[0]); end
    if (n < 1 || qv[0] !== 100) begin bad++; $display("FAIL b2b q0 got %0d exp 100", qv[0]); end
    if (n < 1 || rv[0] !== 0) begin bad++; $display("FAIL b2b r0 got %0d exp 0", rv[0]); end
    if (n < 2 || qv[1] !== 2) begin bad++; $display("FAIL b2b q1 got %0d exp 2", qv[1]); end
    if (n < 2 || rv[1] !== 1) begin bad++; $display("FAIL b2b r1 got %0d exp 1", rv[1]); end
    repeat (3) @(negedge clk);
  endtask

`ifdef DIV32_SIGNED_EN
  task automatic test_signed();
    check_op("s -7/2", 32'hFFFF_FFF9, 2, 1);
    check_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1);
    check_op("s -5/0", 32'hFFFF_FFFB, 0, 1);
    for (int i = 0; i < 15; i++) check_op("s rand", $urandom, ($urandom >> $urandom_range(0, 31)) | 1, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_abort();
    test_back_to_back();
`ifdef DIV32_SIGNED_EN
    test_signed();
`endif
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
